// File: rtl/i_decode.sv
// i_decode: ID stage of a 5-stage MIPS-style pipeline (regfile, control decode, ID/EX register).
// Latency: one cycle from IF_ID_* inputs to ID_EX_* outputs; STALL is combinational.
// Backpressure: STALL asks upstream to hold PC and IF/ID while a bubble is inserted; EX_MEM_PCSrc flushes.
//
// Ports:
//   CLK, RST                   clock, synchronous active-high reset
//   IF_ID_INSTR, IF_ID_NPC     instruction and PC+4 from the fetch stage
//   EX_MEM_PCSrc               taken-branch flush request
//   MEM_WB_RegWrite/WriteReg/WriteData   register file write port
//   STALL                      load-use hazard indication
//   ID_EX_*                    registered decode results for the execute stage
module i_decode (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IF_ID_INSTR,
  input  logic [31:0] IF_ID_NPC,
  input  logic        EX_MEM_PCSrc,
  input  logic        MEM_WB_RegWrite,
  input  logic [4:0]  MEM_WB_WriteReg,
  input  logic [31:0] MEM_WB_WriteData,
  output logic        STALL,
  output logic [31:0] ID_EX_NPC,
  output logic [31:0] ID_EX_A,
  output logic [31:0] ID_EX_B,
  output logic [31:0] ID_EX_IMM,
  output logic [4:0]  ID_EX_RT,
  output logic [4:0]  ID_EX_RD,
  output logic [1:0]  ID_EX_WB,
  output logic [2:0]  ID_EX_M,
  output logic [3:0]  ID_EX_EX
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  // Instruction fields
  logic [5:0]  opcode;
  logic [4:0]  rs_idx;
  logic [4:0]  rt_idx;
  logic [4:0]  rd_idx;
  logic [31:0] imm_ext;

  assign opcode  = IF_ID_INSTR[31:26];
  assign rs_idx  = IF_ID_INSTR[25:21];
  assign rt_idx  = IF_ID_INSTR[20:16];
  assign rd_idx  = IF_ID_INSTR[15:11];
  assign imm_ext = {{16{IF_ID_INSTR[15]}}, IF_ID_INSTR[15:0]};

  // Register file
  logic [31:0] regs [32];
  logic        wr_en;
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  // Register 0 is never written, so it only ever holds its reset value of 0.
  assign wr_en = MEM_WB_RegWrite && (MEM_WB_WriteReg != 5'd0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (wr_en) begin
      regs[MEM_WB_WriteReg] <= MEM_WB_WriteData;
    end
  end

  // Read ports: write-through bypass so an instruction decoded in the same
  // cycle as the writeback of its source sees the new value.
  always_comb begin
    rs_val = regs[rs_idx];
    if (rs_idx == 5'd0) begin
      rs_val = 32'd0;
    end else if (wr_en && (MEM_WB_WriteReg == rs_idx)) begin
      rs_val = MEM_WB_WriteData;
    end
  end

  always_comb begin
    rt_val = regs[rt_idx];
    if (rt_idx == 5'd0) begin
      rt_val = 32'd0;
    end else if (wr_en && (MEM_WB_WriteReg == rt_idx)) begin
      rt_val = MEM_WB_WriteData;
    end
  end

  // Control decode: WB = {RegWrite, MemtoReg}, M = {Branch, MemRead, MemWrite},
  // EX = {RegDst, ALUOp[1:0], ALUSrc}.
  logic [1:0] dec_wb;
  logic [2:0] dec_m;
  logic [3:0] dec_ex;

  always_comb begin
    dec_wb = 2'b00;
    dec_m  = 3'b000;
    dec_ex = 4'b0000;
    case (opcode)
      OP_RTYPE: begin
        dec_wb = 2'b10;
        dec_m  = 3'b000;
        dec_ex = 4'b1100;
      end
      OP_LW: begin
        dec_wb = 2'b11;
        dec_m  = 3'b010;
        dec_ex = 4'b0001;
      end
      OP_SW: begin
        dec_wb = 2'b00;
        dec_m  = 3'b001;
        dec_ex = 4'b0001;
      end
      OP_BEQ: begin
        dec_wb = 2'b00;
        dec_m  = 3'b100;
        dec_ex = 4'b0010;
      end
      default: begin
        dec_wb = 2'b00;
        dec_m  = 3'b000;
        dec_ex = 4'b0000;
      end
    endcase
  end

  // Load-use hazard: the lw now in EX writes a register this instruction reads.
  // A pending flush discards this instruction anyway, so no stall is needed.
  // The bubble zeroes ID_EX_M, so the stall self-clears after one cycle.
  logic load_use;

  assign load_use = ID_EX_M[1] && (ID_EX_RT != 5'd0) &&
                    ((ID_EX_RT == rs_idx) || (ID_EX_RT == rt_idx));
  assign STALL    = load_use && !EX_MEM_PCSrc;

  // ID/EX pipeline register: reset > flush > stall bubble > normal load.
  always_ff @(posedge CLK) begin
    if (RST || EX_MEM_PCSrc) begin
      ID_EX_NPC <= 32'd0;
      ID_EX_A   <= 32'd0;
      ID_EX_B   <= 32'd0;
      ID_EX_IMM <= 32'd0;
      ID_EX_RT  <= 5'd0;
      ID_EX_RD  <= 5'd0;
      ID_EX_WB  <= 2'b00;
      ID_EX_M   <= 3'b000;
      ID_EX_EX  <= 4'b0000;
    end else begin
      // Data fields load even while stalled; only control is squashed.
      ID_EX_NPC <= IF_ID_NPC;
      ID_EX_A   <= rs_val;
      ID_EX_B   <= rt_val;
      ID_EX_IMM <= imm_ext;
      ID_EX_RT  <= rt_idx;
      ID_EX_RD  <= rd_idx;
      if (STALL) begin
        ID_EX_WB <= 2'b00;
        ID_EX_M  <= 3'b000;
        ID_EX_EX <= 4'b0000;
      end else begin
        ID_EX_WB <= dec_wb;
        ID_EX_M  <= dec_m;
        ID_EX_EX <= dec_ex;
      end
    end
  end

endmodule

// File: tb/tb_i_decode.sv
// tb_i_decode: directed self-checking bench for i_decode.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Summary line reports comparisons made and failed.
module tb_i_decode;

  logic        CLK;
  logic        RST;
  logic [31:0] IF_ID_INSTR;
  logic [31:0] IF_ID_NPC;
  logic        EX_MEM_PCSrc;
  logic        MEM_WB_RegWrite;
  logic [4:0]  MEM_WB_WriteReg;
  logic [31:0] MEM_WB_WriteData;
  logic        STALL;
  logic [31:0] ID_EX_NPC;
  logic [31:0] ID_EX_A;
  logic [31:0] ID_EX_B;
  logic [31:0] ID_EX_IMM;
  logic [4:0]  ID_EX_RT;
  logic [4:0]  ID_EX_RD;
  logic [1:0]  ID_EX_WB;
  logic [2:0]  ID_EX_M;
  logic [3:0]  ID_EX_EX;

  int n_tests = 0;
  int n_fail  = 0;

  i_decode dut (
    .CLK              (CLK),
    .RST              (RST),
    .IF_ID_INSTR      (IF_ID_INSTR),
    .IF_ID_NPC        (IF_ID_NPC),
    .EX_MEM_PCSrc     (EX_MEM_PCSrc),
    .MEM_WB_RegWrite  (MEM_WB_RegWrite),
    .MEM_WB_WriteReg  (MEM_WB_WriteReg),
    .MEM_WB_WriteData (MEM_WB_WriteData),
    .STALL            (STALL),
    .ID_EX_NPC        (ID_EX_NPC),
    .ID_EX_A          (ID_EX_A),
    .ID_EX_B          (ID_EX_B),
    .ID_EX_IMM        (ID_EX_IMM),
    .ID_EX_RT         (ID_EX_RT),
    .ID_EX_RD         (ID_EX_RD),
    .ID_EX_WB         (ID_EX_WB),
    .ID_EX_M          (ID_EX_M),
    .ID_EX_EX         (ID_EX_EX)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Check that every ID/EX output is zero.
  task automatic check_all_zero(input string tag);
    check({tag, ".npc"}, ID_EX_NPC, 32'd0);
    check({tag, ".a"},   ID_EX_A,   32'd0);
    check({tag, ".b"},   ID_EX_B,   32'd0);
    check({tag, ".imm"}, ID_EX_IMM, 32'd0);
    check({tag, ".rt"},  {27'd0, ID_EX_RT}, 32'd0);
    check({tag, ".rd"},  {27'd0, ID_EX_RD}, 32'd0);
    check({tag, ".wb"},  {30'd0, ID_EX_WB}, 32'd0);
    check({tag, ".m"},   {29'd0, ID_EX_M},  32'd0);
    check({tag, ".ex"},  {28'd0, ID_EX_EX}, 32'd0);
  endtask

  task automatic wr(input logic en, input logic [4:0] idx, input logic [31:0] dat);
    MEM_WB_RegWrite  = en;
    MEM_WB_WriteReg  = idx;
    MEM_WB_WriteData = dat;
  endtask

  initial begin
    RST          = 1'b1;
    IF_ID_INSTR  = 32'd0;
    IF_ID_NPC    = 32'd0;
    EX_MEM_PCSrc = 1'b0;
    wr(1'b0, 5'd0, 32'd0);
    #1;
    step();
    step();
    RST = 1'b0;
    #1;
    check_all_zero("reset");
    check("reset.stall", {31'd0, STALL}, 32'd0);

    // Write r5 = 0xAA, then decode add r6,r5,r6.
    wr(1'b1, 5'd5, 32'h0000_00AA);
    step();
    wr(1'b0, 5'd0, 32'd0);
    IF_ID_INSTR = 32'h00A6_3020;
    IF_ID_NPC   = 32'h0000_0104;
    step();
    check("add.a",   ID_EX_A,   32'h0000_00AA);
    check("add.b",   ID_EX_B,   32'd0);
    check("add.wb",  {30'd0, ID_EX_WB}, 32'd2);
    check("add.m",   {29'd0, ID_EX_M},  32'd0);
    check("add.ex",  {28'd0, ID_EX_EX}, 32'hC);
    check("add.rt",  {27'd0, ID_EX_RT}, 32'd6);
    check("add.rd",  {27'd0, ID_EX_RD}, 32'd6);
    check("add.npc", ID_EX_NPC, 32'h0000_0104);
    check("add.imm", ID_EX_IMM, 32'h0000_3020);

    // Same-cycle write r7 while decoding rs=7: bypass.
    wr(1'b1, 5'd7, 32'h0000_1234);
    IF_ID_INSTR = 32'h00E0_0800;
    step();
    check("bypass.a", ID_EX_A, 32'h0000_1234);
    wr(1'b0, 5'd0, 32'd0);
    step();
    check("r7.stored", ID_EX_A, 32'h0000_1234);

    // Write to r0 is ignored, including on the bypass path.
    wr(1'b1, 5'd0, 32'hFFFF_FFFF);
    IF_ID_INSTR = 32'h0000_0000;
    step();
    check("r0.bypass", ID_EX_A, 32'd0);
    wr(1'b0, 5'd0, 32'd0);
    step();
    check("r0.read", ID_EX_A, 32'd0);

    // lw r8,4(r0) followed by add r9,r8,r5: one-cycle load-use stall.
    IF_ID_INSTR = 32'h8C08_0004;
    step();
    check("lw.m",   {29'd0, ID_EX_M},  32'd2);
    check("lw.wb",  {30'd0, ID_EX_WB}, 32'd3);
    check("lw.ex",  {28'd0, ID_EX_EX}, 32'd1);
    check("lw.rt",  {27'd0, ID_EX_RT}, 32'd8);
    check("lw.imm", ID_EX_IMM, 32'd4);
    IF_ID_INSTR = 32'h0105_4800;
    #1;
    check("lu.stall", {31'd0, STALL}, 32'd1);
    step();
    check("bubble.m",  {29'd0, ID_EX_M},  32'd0);
    check("bubble.wb", {30'd0, ID_EX_WB}, 32'd0);
    check("bubble.ex", {28'd0, ID_EX_EX}, 32'd0);
    check("bubble.rd", {27'd0, ID_EX_RD}, 32'd9);
    check("bubble.b",  ID_EX_B, 32'h0000_00AA);
    check("bubble.stall", {31'd0, STALL}, 32'd0);
    step();
    check("issue.wb", {30'd0, ID_EX_WB}, 32'd2);
    check("issue.ex", {28'd0, ID_EX_EX}, 32'hC);
    check("issue.stall", {31'd0, STALL}, 32'd0);

    // Flush during a load-use: no stall, everything zero; write r10 meanwhile.
    IF_ID_INSTR = 32'h8C08_0004;
    step();
    IF_ID_INSTR  = 32'h0105_4800;
    EX_MEM_PCSrc = 1'b1;
    wr(1'b1, 5'd10, 32'h0000_0055);
    #1;
    check("flush.stall", {31'd0, STALL}, 32'd0);
    step();
    EX_MEM_PCSrc = 1'b0;
    wr(1'b0, 5'd0, 32'd0);
    check_all_zero("flush");

    // beq with negative immediate.
    IF_ID_INSTR = 32'h10A6_8000;
    step();
    check("beq.imm", ID_EX_IMM, 32'hFFFF_8000);
    check("beq.m",   {29'd0, ID_EX_M},  32'd4);
    check("beq.ex",  {28'd0, ID_EX_EX}, 32'd2);
    check("beq.wb",  {30'd0, ID_EX_WB}, 32'd0);

    // sw
    IF_ID_INSTR = 32'hACA6_0008;
    step();
    check("sw.m",  {29'd0, ID_EX_M},  32'd1);
    check("sw.ex", {28'd0, ID_EX_EX}, 32'd1);
    check("sw.wb", {30'd0, ID_EX_WB}, 32'd0);

    // Unknown opcode 0x3F: no control.
    IF_ID_INSTR = 32'hFCA6_0010;
    step();
    check("op3f.m",  {29'd0, ID_EX_M},  32'd0);
    check("op3f.ex", {28'd0, ID_EX_EX}, 32'd0);
    check("op3f.wb", {30'd0, ID_EX_WB}, 32'd0);

    // r10 was written during the flush cycle.
    IF_ID_INSTR = 32'h0140_0000;
    step();
    check("r10.flushwr", ID_EX_A, 32'h0000_0055);

    // Reset in the middle of a stall.
    IF_ID_INSTR = 32'h8C08_0004;
    step();
    IF_ID_INSTR = 32'h0105_4800;
    #1;
    check("pre_rst.stall", {31'd0, STALL}, 32'd1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check_all_zero("rst");
    check("rst.stall", {31'd0, STALL}, 32'd0);

    // All registers cleared.
    IF_ID_INSTR = 32'h00A7_0000;
    step();
    check("rst.r5", ID_EX_A, 32'd0);
    check("rst.r7", ID_EX_B, 32'd0);
    IF_ID_INSTR = 32'h0145_0000;
    step();
    check("rst.r10", ID_EX_A, 32'd0);
    check("rst.r5b", ID_EX_B, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i_decode.md
I_DECODE -- requirements
Module: i_decode

Interface
REQ-001 SHALL have no parameters; all widths fixed (32-bit data, 5-bit register index).
REQ-002 SHALL have port CLK input 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST input 1, synchronous, active-high reset.
REQ-004 SHALL have port IF_ID_INSTR input 32, instruction from fetch stage.
REQ-005 SHALL have port IF_ID_NPC input 32, PC+4 from fetch stage.
REQ-006 SHALL have port EX_MEM_PCSrc input 1, taken-branch flush request.
REQ-007 SHALL have port MEM_WB_RegWrite input 1, writeback enable.
REQ-008 SHALL have port MEM_WB_WriteReg input 5, writeback register index.
REQ-009 SHALL have port MEM_WB_WriteData input 32, writeback data.
REQ-010 SHALL have port STALL output 1, combinational load-use hazard; upstream holds PC and IF/ID while high.
REQ-011 SHALL have ports ID_EX_NPC, ID_EX_A, ID_EX_B and ID_EX_IMM, each output 32, registered: NPC, rs value, rt value and sign-extended imm[15:0] respectively.
REQ-012 SHALL have ports ID_EX_RT and ID_EX_RD, each output 5, registered instr[20:16] and instr[15:11].
REQ-013 SHALL have port ID_EX_WB output 2, registered {RegWrite, MemtoReg}.
REQ-014 SHALL have port ID_EX_M output 3, registered {Branch, MemRead, MemWrite}.
REQ-015 SHALL have port ID_EX_EX output 4, registered {RegDst, ALUOp[1:0], ALUSrc}.

Function
REQ-016 SHALL decode opcode instr[31:26] into {WB, M, EX} as follows:
- 0x00 (R-type): 2'b10, 3'b000, 4'b1100.
- 0x23 (lw): 2'b11, 3'b010, 4'b0001.
- 0x2B (sw): 2'b00, 3'b001, 4'b0001.
- 0x04 (beq): 2'b00, 3'b100, 4'b0010.
- Any other opcode: all zero.
REQ-017 SHALL contain a 32x32 register file: rs = instr[25:21], rt = instr[20:16]; two asynchronous read ports, one synchronous write port.
REQ-018 SHALL write MEM_WB_WriteData into register MEM_WB_WriteReg on the rising edge when MEM_WB_RegWrite=1 and MEM_WB_WriteReg!=0.
REQ-019 SHALL keep register 0 reading 0 regardless of writes.
REQ-020 SHALL bypass write data to a read port in the same cycle when RegWrite=1, WriteReg!=0 and WriteReg equals that port's index.
REQ-021 SHALL sign-extend: ID_EX_IMM = {16{instr[15]}, instr[15:0]}.
REQ-022 SHALL load all ID/EX outputs on every rising edge; latency is exactly one cycle from IF_ID inputs to ID_EX outputs.
REQ-023 SHALL assert STALL=1 when ID_EX_M[1] (MemRead)=1, ID_EX_RT!=0, and ID_EX_RT equals rs or rt of the current instruction, and EX_MEM_PCSrc=0.
REQ-024 SHALL, when STALL=1, load ID_EX_WB, ID_EX_M and ID_EX_EX with zero (bubble); the data fields load normally.
REQ-025 SHALL, when EX_MEM_PCSrc=1, load all ID/EX outputs with zero (flush); flush overrides stall, and STALL is 0 in that cycle.
REQ-026 SHALL assert STALL for exactly one cycle per load-use pair, because the bubble clears ID_EX_M[1] on the next edge.
REQ-027 SHALL let register-file writes proceed during stall and flush cycles.

Reset
REQ-028 SHALL, when RST=1 at a rising edge, clear all ID/EX outputs and all 32 registers to 0; RST has priority over writes, flush and stall.
REQ-029 SHALL keep STALL=0 while all ID/EX outputs are zero following reset.
REQ-030 SHALL, on RST asserted mid-stall, output zeros on the next edge with STALL=0 thereafter until a new lw is decoded.

Verification
REQ-031 SHALL verify: write reg 5=0x0000_00AA via MEM_WB, then decode instr 0x00A63020 (add r6,r5,r6) -> ID_EX_A=0xAA, ID_EX_WB=2'b10, ID_EX_EX=4'b1100 one cycle later.
REQ-032 SHALL verify: same-cycle write r7=0x1234 while decoding rs=7 -> ID_EX_A=0x1234 (bypass); attempt write r0=0xFFFF_FFFF -> r0 reads 0.
REQ-033 SHALL verify: lw r8 (0x8C080004) followed by add using rs=8 -> STALL=1 for one cycle, ID_EX_M=3'b000 bubble, then add issues normally.
REQ-034 SHALL verify: EX_MEM_PCSrc=1 during a detected load-use -> STALL=0, all ID/EX outputs 0 next cycle.
REQ-035 SHALL verify: imm 0x8000 -> ID_EX_IMM=0xFFFF_8000; opcode 0x3F -> all control outputs zero.
REQ-036 SHALL verify: RST pulse after registers are populated -> every register reads 0, all ID/EX outputs 0.
